block_sum_sat: RTL and testbench
================================

// Module: block_sum_sat
// PURPOSE
//   Downstream consumer of the 8->32 sign-extension stage. Accepts a stream of sign-extended
//   32-bit two's-complement samples, sums each block of BLOCK_LEN consecutive samples with
//   saturation, and presents each block sum on a one-entry ready/valid output buffer.
//   Accumulation continues while a finished sum waits; input stalls only when it must.
// PARAMETERS
//   BLOCK_LEN  4   samples per block; legal range 2..256
// PORTS
//   clk        in   1   single clock, all state on posedge
//   reset      in   1   synchronous, active-high
//   in_valid   in   1   sample on 'in' is valid this cycle
//   in_ready   out  1   block can take a sample this cycle
//   in         in   32  signed sample (already sign-extended from 8 bits)
//   out_valid  out  1   block sum on 'out' is valid
//   out_ready  in   1   consumer takes 'out' this cycle
//   out        out  32  signed saturated block sum
//   out_sat    out  1   saturation occurred anywhere in the block reported on 'out'
// BEHAVIOUR
//   Reset (sync, clk edge with reset=1): acc=0, cnt=0, sat_flag=0, out_valid=0, out=0, out_sat=0.
//     Reset overrides everything incl. a simultaneous accept; a partial block is discarded.
//   Accept: sample taken when in_valid & in_ready on a clk edge. Output handshake: out_valid & out_ready.
//   Arithmetic: next = acc + in, computed 33-bit signed; clamp to 32'h7FFF_FFFF / 32'h8000_0000
//     on overflow and set sat_flag. Once clamped, later samples add to the clamped value.
//   cnt: 0..BLOCK_LEN-1, width $clog2(BLOCK_LEN); increments per accepted sample.
//   Block completion (accept with cnt==BLOCK_LEN-1): next edge loads out<=sat(acc+in),
//     out_sat<=sat_flag|overflow_now, out_valid<=1; acc<=0, cnt<=0, sat_flag<=0.
//     Latency: last sample accepted at edge N -> out_valid high after edge N.
//   Output buffer states: EMPTY (out_valid=0) / FULL (out_valid=1).
//     FULL & out_ready & no completion -> EMPTY. FULL & out_ready & completion same edge -> stays
//     FULL with new sum (drain and refill on one edge, no bubble). out/out_sat stable while FULL & ~out_ready.
//   in_ready = ~(out_valid & ~out_ready & cnt==BLOCK_LEN-1): combinational; samples 0..BLOCK_LEN-2
//     of the next block are always accepted; only the completing sample stalls on a full, blocked buffer.
//   in_ready does not depend on in_valid (no comb loop). out_valid never drops without out_ready.
//   in ignored when not accepted; X on 'in' with in_valid=0 must not propagate into acc.
// STRUCTURE
//   Shared package blk_pkg: localparams SAT_MAX=32'h7FFF_FFFF, SAT_MIN=32'h8000_0000,
//     typedef logic signed [31:0] sample_t.
//   One sub-module: sat_add32 (comb: a,b -> sum, ovf) used for the accumulate path.
//   Top holds acc/cnt/sat_flag registers and the one-entry output buffer.
// TESTING
//   1 Reset then samples 1,2,3,4 (BLOCK_LEN=4), out_ready=1 -> out=10, out_sat=0, out_valid one cycle.
//   2 Samples -128,-128,-128,-128 (from sign-extension of 8'h80) -> out=32'hFFFF_FE00 (-512), out_sat=0.
//   3 Samples 32'h7FFF_FFF0,32'h20,-1,0 -> first add clamps to 32'h7FFF_FFFF; out=32'h7FFF_FFFE, out_sat=1;
//     next block 1,1,1,1 -> out=4, out_sat=0 (flag cleared per block).
//   4 out_ready=0 after block A=10 completes; feed 5,5,5 accepted, 4th sample sees in_ready=0;
//     raise out_ready -> A drained, 4th accepted same edge, then out=20 next cycle; out held 10 throughout stall.
//   5 Back-to-back blocks with out_ready=1, in_valid=1 every cycle -> one out_valid per 4 cycles, no stall.
//   6 Reset asserted after 2 samples of a block and concurrently with a completing accept -> out_valid=0,
//     next 4 samples 1,1,1,1 yield out=4 (partial block discarded).

Source files
------------

// File: rtl/blk_pkg.sv
`default_nettype none
// ============================================================================
// Package     : blk_pkg
// Description : Shared sample type, saturation limits and output-buffer state
//               encoding for the block summing stage.
// Revision    : 1.0  initial release
// ============================================================================
package blk_pkg;

    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

    typedef logic signed [31:0] sample_t;

    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/block_sum_sat_if.sv
`default_nettype none
// ============================================================================
// Interface   : block_sum_sat_if
// Description : Sample input stream and block-sum output stream, both
//               ready/valid. The slave modport is the summing block's view.
// Revision    : 1.0  initial release
// ============================================================================
interface block_sum_sat_if;
    import blk_pkg::*;

    logic    in_valid;
    logic    in_ready;
    sample_t in;
    logic    out_valid;
    logic    out_ready;
    sample_t out;
    logic    out_sat;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out, out_sat
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out, out_sat
    );

endinterface
`default_nettype wire

// File: rtl/sat_add32.sv
`default_nettype none
// ============================================================================
// Module      : sat_add32
// Description : Combinational 32-bit signed add, clamped to the int32 range,
//               with an overflow indication.
// Revision    : 1.0  initial release
// ============================================================================
module sat_add32
    import blk_pkg::*;
(
    input  sample_t a,
    input  sample_t b,
    output sample_t sum,
    output logic    ovf
);

    logic [32:0] w_wide;

    // One guard bit: overflow iff the two top bits of the 33-bit sum differ.
    assign w_wide = {a[31], a} + {b[31], b};
    assign ovf    = w_wide[32] ^ w_wide[31];
    assign sum    = ovf ? (w_wide[32] ? SAT_MIN : SAT_MAX) : w_wide[31:0];

endmodule
`default_nettype wire

// File: rtl/block_sum_sat.sv
`default_nettype none
// ============================================================================
// Module      : block_sum_sat
// Description : Saturating sum of each BLOCK_LEN-sample block, presented on a
//               one-entry ready/valid output buffer that drains and refills
//               on the same edge.
// Revision    : 1.0  initial release
// ============================================================================
module block_sum_sat
    import blk_pkg::*;
#(
    parameter int BLOCK_LEN = 4
)(
    input  wire logic         clk,
    input  wire logic         reset,
    block_sum_sat_if.slave    bus
);

    localparam int              CNT_W      = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    sample_t          r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat_flag;
    sample_t          r_out;
    logic             r_out_sat;
    buf_state_t       r_state;
    buf_state_t       w_state_next;

    logic             w_last;
    logic             w_accept;
    logic             w_complete;
    sample_t          w_addend;
    sample_t          w_sum;
    logic             w_ovf;

    assign w_last     = (r_cnt == c_LAST_CNT);
    // Only the completing sample has to wait for a full, blocked buffer.
    assign bus.in_ready = ~((r_state == BUF_FULL) & ~bus.out_ready & w_last);
    assign w_accept   = bus.in_valid & bus.in_ready;
    assign w_complete = w_accept & w_last;
    // Gate the data so an idle (possibly X) input never reaches the adder.
    assign w_addend   = w_accept ? bus.in : '0;

    sat_add32 u_sat_add32 (
        .a   (r_acc),
        .b   (w_addend),
        .sum (w_sum),
        .ovf (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_sat_flag <= 1'b0;
            r_out      <= '0;
            r_out_sat  <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                r_out      <= w_sum;
                r_out_sat  <= r_sat_flag | w_ovf;
                r_acc      <= '0;
                r_cnt      <= '0;
                r_sat_flag <= 1'b0;
            end else begin
                r_acc      <= w_sum;
                r_cnt      <= r_cnt + CNT_W'(1);
                r_sat_flag <= r_sat_flag | w_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BUF_EMPTY: if (w_complete)                   w_state_next = BUF_FULL;
            BUF_FULL:  if (bus.out_ready & ~w_complete)  w_state_next = BUF_EMPTY;
            default:                                     w_state_next = BUF_EMPTY;
        endcase
    end

    assign bus.out_valid = (r_state == BUF_FULL);
    assign bus.out       = r_out;
    assign bus.out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_block_sum_sat.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_sum_sat
// Description : Self-checking bench for block_sum_sat against a behavioural
//               block-sum model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_block_sum_sat;
    import blk_pkg::*;

    localparam int     BL    = 4;
    localparam longint L_MAX = 64'sd2147483647;
    localparam longint L_MIN = -64'sd2147483648;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    block_sum_sat_if bus ();

    block_sum_sat #(.BLOCK_LEN(BL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: sample list per block, output buffer as (valid, sum, sat).
    logic        m_valid;
    logic [31:0] m_out;
    logic        m_sat;
    int          m_cnt;
    longint      m_samp [BL];
    logic        m_in_ready;

    assign m_in_ready = !(m_valid && !bus.out_ready && m_cnt == BL - 1);

    always @(posedge clk) begin : model
        automatic longint acc;
        automatic logic   sat;
        if (reset) begin
            m_valid <= 1'b0;
            m_out   <= '0;
            m_sat   <= 1'b0;
            m_cnt   <= 0;
        end else begin
            if (bus.in_valid && m_in_ready) begin
                if (m_cnt == BL - 1) begin
                    acc = 0;
                    sat = 1'b0;
                    for (int i = 0; i < BL; i++) begin
                        acc = acc + ((i == BL - 1) ? longint'(bus.in) : m_samp[i]);
                        if (acc > L_MAX) begin
                            acc = L_MAX;
                            sat = 1'b1;
                        end else if (acc < L_MIN) begin
                            acc = L_MIN;
                            sat = 1'b1;
                        end
                    end
                    m_out   <= acc[31:0];
                    m_sat   <= sat;
                    m_valid <= 1'b1;
                    m_cnt   <= 0;
                end else begin
                    m_samp[m_cnt] <= longint'(bus.in);
                    m_cnt         <= m_cnt + 1;
                end
            end
            if (!(bus.in_valid && m_in_ready && m_cnt == BL - 1) && m_valid && bus.out_ready)
                m_valid <= 1'b0;
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic rdy);
        bus.in_valid  = v;
        bus.in        = d;
        bus.out_ready = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, $urandom, 1'b0);
        tick;
        tick;
        checks += 4;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.out !== 32'h0)      begin errors++; $display("FAIL reset_out: got %h expected 00000000", bus.out); end
        if (bus.out_sat !== 1'b0)   begin errors++; $display("FAIL reset_out_sat: got %b expected 0", bus.out_sat); end
        if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, i, 1'b1);
            tick;
        end
        checks += 3;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.out_valid); end
        if (bus.out !== 32'd10)     begin errors++; $display("FAIL basic_sum: got %h expected 0000000a", bus.out); end
        if (bus.out_sat !== 1'b0)   begin errors++; $display("FAIL basic_sat: got %b expected 0", bus.out_sat); end
        drive(1'b0, $urandom, 1'b1);
        tick;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_negative;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hFFFF_FF80, 1'b1);
            tick;
        end
        checks += 3;
        if (bus.out_valid !== 1'b1)    begin errors++; $display("FAIL neg_valid: got %b expected 1", bus.out_valid); end
        if (bus.out !== 32'hFFFF_FE00) begin errors++; $display("FAIL neg_sum: got %h expected fffffe00", bus.out); end
        if (bus.out_sat !== 1'b0)      begin errors++; $display("FAIL neg_sat: got %b expected 0", bus.out_sat); end
    endtask

    task automatic test_saturation;
        logic [31:0] samp [4];
        samp[0] = 32'h7FFF_FFF0; samp[1] = 32'h0000_0020; samp[2] = 32'hFFFF_FFFF; samp[3] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, samp[i], 1'b1);
            tick;
        end
        checks += 3;
        if (bus.out_valid !== 1'b1)    begin errors++; $display("FAIL sat_valid: got %b expected 1", bus.out_valid); end
        if (bus.out !== 32'h7FFF_FFFE) begin errors++; $display("FAIL sat_sum: got %h expected 7ffffffe", bus.out); end
        if (bus.out_sat !== 1'b1)      begin errors++; $display("FAIL sat_flag: got %b expected 1", bus.out_sat); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'd1, 1'b1);
            tick;
        end
        checks += 2;
        if (bus.out !== 32'd4)    begin errors++; $display("FAIL sat_next_sum: got %h expected 00000004", bus.out); end
        if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL sat_flag_cleared: got %b expected 0", bus.out_sat); end
        drive(1'b0, $urandom, 1'b1);
        tick;
    endtask

    task automatic test_stall;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, i, 1'b1);
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'd5, 1'b0);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_early_ready: got %b expected 1", bus.in_ready); end
            tick;
        end
        drive(1'b1, 32'd5, 1'b0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_last_ready: got %b expected 0", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks += 2;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid: got %b expected 1", bus.out_valid); end
            if (bus.out !== 32'd10)     begin errors++; $display("FAIL stall_hold_out: got %h expected 0000000a", bus.out); end
        end
        drive(1'b1, 32'd5, 1'b1);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b expected 1", bus.in_ready); end
        tick;
        checks += 2;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_refill_valid: got %b expected 1", bus.out_valid); end
        if (bus.out !== 32'd20)     begin errors++; $display("FAIL stall_refill_out: got %h expected 00000014", bus.out); end
        drive(1'b0, $urandom, 1'b1);
        tick;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back;
        int n_valid = 0;
        int n_stall = 0;
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            drive(1'b1, {{24{b[7]}}, b}, 1'b1);
            #1;
            if (bus.in_ready !== 1'b1) n_stall++;
            tick;
            if (bus.out_valid === 1'b1) n_valid++;
            checks++;
            if (bus.out_valid !== m_valid || (m_valid && (bus.out !== m_out || bus.out_sat !== m_sat))) begin
                errors++;
                $display("FAIL b2b_out: got v=%b %h s=%b expected v=%b %h s=%b",
                         bus.out_valid, bus.out, bus.out_sat, m_valid, m_out, m_sat);
            end
        end
        checks += 2;
        if (n_valid != 4) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 4", n_valid); end
        if (n_stall != 0) begin errors++; $display("FAIL b2b_stalls: got %0d expected 0", n_stall); end
        drive(1'b0, $urandom, 1'b1);
        tick;
    endtask

    task automatic test_reset_mid_block;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'd7, 1'b1);
            tick;
        end
        reset = 1'b1;
        drive(1'b0, $urandom, 1'b1);
        tick;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'd9, 1'b1);
            tick;
        end
        reset = 1'b1;
        drive(1'b1, 32'd9, 1'b1);
        tick;
        reset = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", bus.out_valid); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'd1, 1'b1);
            tick;
        end
        checks += 3;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_after_valid: got %b expected 1", bus.out_valid); end
        if (bus.out !== 32'd4)      begin errors++; $display("FAIL rst_mid_after_sum: got %h expected 00000004", bus.out); end
        if (bus.out_sat !== 1'b0)   begin errors++; $display("FAIL rst_mid_after_sat: got %b expected 0", bus.out_sat); end
        drive(1'b0, $urandom, 1'b1);
        tick;
    endtask

    task automatic test_random;
        logic        v;
        logic        rdy;
        logic [31:0] d;
        logic [7:0]  b;
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            b   = 8'($urandom);
            if (!v)                            d = $urandom;
            else if ($urandom_range(0, 5) == 0) d = $urandom;
            else                               d = {{24{b[7]}}, b};
            reset = ($urandom_range(0, 149) == 0);
            drive(v, d, rdy);
            #1;
            checks++;
            if (bus.in_ready !== m_in_ready) begin
                errors++;
                $display("FAIL rand_in_ready: got %b expected %b", bus.in_ready, m_in_ready);
            end
            tick;
            checks++;
            if (bus.out_valid !== m_valid || (m_valid && (bus.out !== m_out || bus.out_sat !== m_sat))) begin
                errors++;
                $display("FAIL rand_out: got v=%b %h s=%b expected v=%b %h s=%b",
                         bus.out_valid, bus.out, bus.out_sat, m_valid, m_out, m_sat);
            end
        end
        reset = 1'b0;
        drive(1'b0, '0, 1'b1);
        tick;
    endtask

    initial begin
        drive(1'b0, '0, 1'b0);
        test_reset;
        test_basic;
        test_negative;
        test_saturation;
        test_stall;
        test_back_to_back;
        test_reset_mid_block;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
